param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo.sv | 113 +++++++++++
 tb/tb_param_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// Synchronous FIFO with configurable width/depth, almost-full/empty thresholds,
// sticky overflow/underflow flags and a selectable standard or first-word-fall-through read port.
module param_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 32,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic                    rd_en,
   input  logic                    clr_err,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    valid,
   output logic                    empty,
   output logic                    full,
   output logic                    almost_empty,
   output logic                    almost_full,
   output logic                    overflow,
   output logic                    underflow,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [1:0]            r_run_sync;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_valid;
   logic                  r_ovf;
   logic                  r_unf;

   logic w_run;
   logic w_empty;
   logic w_full;
   logic w_wr_acc;
   logic w_rd_acc;
   logic w_ovf_evt;
   logic w_unf_evt;

   // Handshake: wr_en/rd_en are requests sampled at the rising edge; a write is
   // accepted only when not full and a read only when not empty (pre-edge state).
   // A request that is not accepted has no effect other than raising its error flag.
   assign w_run     = r_run_sync[1];
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == C_DEPTH);
   assign w_wr_acc  = w_run & wr_en & ~w_full;
   assign w_rd_acc  = w_run & rd_en & ~w_empty;
   assign w_ovf_evt = w_run & wr_en & w_full;
   assign w_unf_evt = w_run & rd_en & w_empty;

   // Reset release is re-timed so no access lands on the edge that releases it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_run_sync <= 2'b00;
      else      r_run_sync <= {r_run_sync[0], 1'b1};
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_ovf <= w_ovf_evt | (r_ovf & ~clr_err);
         r_unf <= w_unf_evt | (r_unf & ~clr_err);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_rd_acc;
         if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
      end
   end

   // In fall-through mode the head word is shown combinationally; zero while empty.
   assign data_out     = (FWFT != 0) ? (w_empty ? '0 : r_mem[r_rd_ptr]) : r_dout;
   assign valid        = (FWFT != 0) ? ~w_empty : r_valid;
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_empty = (r_count <= C_AE);
   assign almost_full  = (r_count >= C_AF);
   assign overflow     = r_ovf;
   assign underflow    = r_unf;
   assign fifo_count   = r_count;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: table vectors plus scoreboard-checked sequences on a standard-read
// instance (DEPTH=32) and a small first-word-fall-through instance.
module tb_param_fifo;

   logic       clk;
   logic       rst;
   logic       wr_en, rd_en, clr_err;
   logic [7:0] data_in, data_out;
   logic       valid, empty, full, almost_empty, almost_full, overflow, underflow;
   logic [5:0] fifo_count;

   logic       f_wr, f_rd, f_clr;
   logic [7:0] f_din, f_dout;
   logic       f_valid, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
   logic [2:0] f_count;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];
   int         m_count;
   logic [7:0] m_dout;
   logic       m_ovf, m_unf;

   typedef struct {
      logic       wr, rd, clr;
      logic [7:0] din;
      int         cnt;
      logic       emp, ful, ae, af, ovf, unf;
   } vec_t;
   vec_t tbl[12];

   param_fifo #(.DATA_WIDTH(8), .DEPTH(32), .AF_LEVEL(30), .AE_LEVEL(2), .FWFT(0)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
      .data_in(data_in), .data_out(data_out), .valid(valid), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full), .overflow(overflow),
      .underflow(underflow), .fifo_count(fifo_count)
   );

   param_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_dut_fwft (
      .clk(clk), .rst(rst), .wr_en(f_wr), .rd_en(f_rd), .clr_err(f_clr),
      .data_in(f_din), .data_out(f_dout), .valid(f_valid), .empty(f_empty), .full(f_full),
      .almost_empty(f_ae), .almost_full(f_af), .overflow(f_ovf),
      .underflow(f_unf), .fifo_count(f_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      m_count = 0;
      m_dout  = 8'h00;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_count"}, 32'(fifo_count), 0);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_ae"}, 32'(almost_empty), 1);
      chk({tag, "_full"}, 32'(full), 0);
      chk({tag, "_af"}, 32'(almost_full), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
      chk({tag, "_unf"}, 32'(underflow), 0);
      chk({tag, "_valid"}, 32'(valid), 0);
      chk({tag, "_dout"}, 32'(data_out), 0);
   endtask

   // one clock of stimulus on the standard instance, checked against the scoreboard
   task automatic step(input logic wr, input logic rd, input logic clr, input logic [7:0] din);
      logic       wa, ra;
      logic [7:0] exp_d;
      wr_en = wr; rd_en = rd; clr_err = clr; data_in = din;
      wa = wr && (m_count < 32);
      ra = rd && (m_count > 0);
      exp_d = m_dout;
      m_ovf = (wr && (m_count == 32)) || (m_ovf && !clr);
      m_unf = (rd && (m_count == 0)) || (m_unf && !clr);
      if (ra) exp_d = exp_q.pop_front();
      if (wa) exp_q.push_back(din);
      m_count = m_count + int'(wa) - int'(ra);
      m_dout  = exp_d;
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
      chk("valid", 32'(valid), 32'(ra));
      chk("data_out", 32'(data_out), 32'(exp_d));
      chk("count", 32'(fifo_count), 32'(m_count));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      #1;
      check_reset_vals("rst");
      model_clear();
      release_reset();
   endtask

   initial begin
      int ae_at, af_at;
      rst = 1'b0; wr_en = 0; rd_en = 0; clr_err = 0; data_in = 0;
      f_wr = 0; f_rd = 0; f_clr = 0; f_din = 0;
      model_clear();

      tbl[0]  = '{1, 1'b1 ^ 1'b1 ? 0 : 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 1};
      tbl[0]  = '{0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 1};
      tbl[1]  = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0};
      tbl[2]  = '{1, 0, 0, 8'hA1, 1, 0, 0, 1, 0, 0, 0};
      tbl[3]  = '{1, 0, 0, 8'hA2, 2, 0, 0, 1, 0, 0, 0};
      tbl[4]  = '{1, 0, 0, 8'hA3, 3, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{1, 1, 0, 8'hB4, 3, 0, 0, 0, 0, 0, 0};
      tbl[6]  = '{0, 1, 0, 8'h00, 2, 0, 0, 1, 0, 0, 0};
      tbl[7]  = '{0, 1, 0, 8'h00, 1, 0, 0, 1, 0, 0, 0};
      tbl[8]  = '{0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0};
      tbl[9]  = '{1, 1, 0, 8'hC5, 1, 0, 0, 1, 0, 0, 1};
      tbl[10] = '{0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 0, 0};
      tbl[11] = '{0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0};

      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("init");
      chk("fwft_reset_valid", 32'(f_valid), 0);
      chk("fwft_reset_empty", 32'(f_empty), 1);
      release_reset();

      // table vectors
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
         chk($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
         chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].ful));
         chk($sformatf("tbl%0d_ae", i), 32'(almost_empty), 32'(tbl[i].ae));
         chk($sformatf("tbl%0d_af", i), 32'(almost_full), 32'(tbl[i].af));
         chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
         chk($sformatf("tbl%0d_unf", i), 32'(underflow), 32'(tbl[i].unf));
      end

      // fill to full, overflow, drain in order
      for (int i = 0; i < 32; i++) step(1, 0, 0, 8'(i));
      chk("fill_full", 32'(full), 1);
      chk("fill_count", 32'(fifo_count), 32);
      chk("fill_af", 32'(almost_full), 1);
      step(1, 0, 0, 8'hFF);
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_count", 32'(fifo_count), 32);
      step(1, 1, 0, 8'hEE);
      chk("full_wr_rd_count", 32'(fifo_count), 31);
      step(1, 0, 0, 8'h20);
      for (int i = 0; i < 32; i++) step(0, 1, 0, 8'h00);
      chk("drain_empty", 32'(empty), 1);
      step(0, 0, 1, 8'h00);
      chk("ovf_cleared", 32'(overflow), 0);

      // steady state at 16 with simultaneous traffic, pointers wrap several times
      for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(i));
      for (int i = 0; i < 100; i++) step(1, 1, 0, 8'(16 + i));
      chk("steady_count", 32'(fifo_count), 16);
      for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);

      // random traffic
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
              8'($urandom_range(0, 255)));
      while (m_count > 0) step(0, 1, 0, 8'h00);
      step(0, 0, 1, 8'h00);

      // threshold crossings one word at a time
      reset_dut();
      ae_at = -1; af_at = -1;
      for (int i = 1; i <= 32; i++) begin
         step(1, 0, 0, 8'(8'h40 + i));
         if (!almost_empty && ae_at < 0) ae_at = int'(fifo_count);
         if (almost_full && af_at < 0) af_at = int'(fifo_count);
      end
      chk("ae_deassert_at", 32'(ae_at), 3);
      chk("af_assert_at", 32'(af_at), 30);
      for (int i = 0; i < 32; i++) step(0, 1, 0, 8'h00);

      // reset mid-operation
      for (int i = 0; i < 10; i++) step(1, 0, 0, 8'(8'h90 + i));
      step(1, 0, 0, 8'h9A);
      #3;
      reset_dut();
      step(1, 0, 0, 8'h3C);
      chk("post_rst_count", 32'(fifo_count), 1);
      step(0, 1, 0, 8'h00);
      chk("post_rst_data", 32'(data_out), 32'h3C);
      chk("post_rst_empty", 32'(empty), 1);

      // first-word-fall-through instance
      step(0, 0, 0, 8'h00);
      chk("fwft_idle_valid", 32'(f_valid), 0);
      f_wr = 1'b1; f_din = 8'hA5;
      @(posedge clk); #1;
      f_wr = 1'b0;
      chk("fwft_valid", 32'(f_valid), 1);
      chk("fwft_data", 32'(f_dout), 32'hA5);
      @(posedge clk); #1;
      chk("fwft_hold_valid", 32'(f_valid), 1);
      chk("fwft_hold_data", 32'(f_dout), 32'hA5);
      f_rd = 1'b1;
      @(posedge clk); #1;
      f_rd = 1'b0;
      chk("fwft_pop_empty", 32'(f_empty), 1);
      chk("fwft_pop_valid", 32'(f_valid), 0);
      chk("fwft_no_unf", 32'(f_unf), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
